fpga_reset_strap_ctrl: RTL and testbench
========================================

# fpga_reset_strap_ctrl

FPGA-only reset and boot-strap conditioner sitting directly upstream of the `CB_heep` instance in the Xilinx top wrapper, clocked by the clock-wizard output. It holds the SoC in reset until the clock wizard reports lock and a fixed settling time has elapsed. It debounces and synchronizes the `boot_select` and `execute_from_flash` switches and freezes them at reset release. It also drives the reset and heartbeat visibility LEDs.

## Interface
- `SYNC_STAGES`, 2, synchronizer depth for all asynchronous inputs (≥2)
- `DEBOUNCE_CYCLES`, 65536, consecutive stable cycles required before a strap change is accepted (≥2)
- `HOLD_CYCLES`, 1024, settling cycles between lock detection and reset release (≥1)
- `CLK_LED_COUNT_LENGTH`, 27, heartbeat counter width
- `clk_i`  in  1  clock-wizard output clock
- `rst_ni`  in  1  asynchronous active-low reset (board reset after polarity fix-up)
- `pll_locked_i`  in  1  clock-wizard lock, asynchronous
- `boot_select_raw_i`  in  1  raw boot-select switch, asynchronous
- `execute_from_flash_raw_i`  in  1  raw execute-from-flash switch, asynchronous
- `soc_rst_no`  out  1  SoC reset, active-low, asserted asynchronously, deasserted synchronously
- `boot_select_o`  out  1  debounced strap, frozen while `soc_rst_no`=1
- `execute_from_flash_o`  out  1  debounced strap, frozen while `soc_rst_no`=1
- `rst_led_o`  out  1  equals `soc_rst_no`
- `clk_led_o`  out  1  heartbeat, MSB of the free-running counter

## Operation
- Reset (`rst_ni`=0): all flops clear immediately. State is WAIT_LOCK. All outputs are 0. Synchronizers, debounced values and counters are 0.
- Each asynchronous input passes through a `SYNC_STAGES` flop chain. Downstream logic uses only the synchronized copies.
- Strap debounce, per strap:
  - When synced ≠ stable, the counter increments.
  - When the counter reaches `DEBOUNCE_CYCLES`-1 while still differing, stable ← synced and the counter clears in that same edge.
  - When synced = stable, the counter clears.
  - The debouncers run in every state.
- FSM (states WAIT_LOCK, HOLD, RUN):
  - WAIT_LOCK: `soc_rst_no`=0. Moves to HOLD on the first edge where synced lock = 1. The hold counter clears.
  - HOLD: `soc_rst_no`=0. The hold counter increments each cycle. If synced lock drops, returns to WAIT_LOCK. When the counter reaches `HOLD_CYCLES`-1, moves to RUN and the strap outputs load the debounced values in the same edge.
  - RUN: `soc_rst_no`=1. The strap outputs hold and ignore further strap changes. If synced lock drops, returns to WAIT_LOCK and `soc_rst_no` falls on that edge. Strap outputs keep their last value.
- `soc_rst_no` is a registered Moore output equal to (state == RUN). It is never driven combinationally from the inputs.
- Heartbeat counter: free-running and wraps to 0. It is reset only by `rst_ni`, not by lock loss.

## Timing
- Edge 1 is the first rising edge with `rst_ni`=1; `pll_locked_i`=1 is held throughout.
- Synced lock is 1 after edge `SYNC_STAGES`.
- The FSM enters HOLD at edge `SYNC_STAGES`+1.
- `soc_rst_no` rises at edge `SYNC_STAGES`+1+`HOLD_CYCLES`; this is edge 19 with defaults and `HOLD_CYCLES`=16.
- Lock loss is seen `SYNC_STAGES` edges after it occurs. `soc_rst_no` falls on the following edge.
- A lock glitch that fits between synchronizer samples is not observed; this is accepted behaviour.
- A strap change is accepted `SYNC_STAGES`+`DEBOUNCE_CYCLES` edges after a stable input edge.
- A strap toggle shorter than `DEBOUNCE_CYCLES` is never accepted.
- Strap accepted on the same edge that FSM enters RUN: the outputs take the old debounced value.
- Asserting `rst_ni` mid-operation forces every output to 0 asynchronously, within the same cycle.

## Structure
- Package `fpga_ctrl_pkg` holds:
  - the `rst_ctrl_state_e` enum (WAIT_LOCK, HOLD, RUN);
  - the default parameter constants.
- Counter widths are `$clog2(DEBOUNCE_CYCLES)` and `$clog2(HOLD_CYCLES)`, with a minimum of 1.
- Sub-module `strap_debouncer` (synchronizer plus debounce counter, parameterized by `SYNC_STAGES` and `DEBOUNCE_CYCLES`) is instantiated once per strap.

## Test plan
Bench parameters: `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=8, `HOLD_CYCLES`=16.
- Power-up, lock high: release `rst_ni` → `soc_rst_no` rises at edge 19, `rst_led_o` follows, and all outputs are 0 before that edge.
- Straps set (1,0) before reset release → `boot_select_o`=1 and `execute_from_flash_o`=0 at edge 19. Toggling `boot_select_raw_i` afterwards leaves the output at 1.
- 5-cycle strap pulse during HOLD → not accepted. A 12-cycle stable change → accepted 10 edges after the change.
- Lock drops in RUN → `soc_rst_no`=0 3 edges later. Lock returns → release occurs 19 edges after synced re-lock timing, with the straps re-latched.
- Lock drops at HOLD counter = 10 → FSM returns to WAIT_LOCK and the full 16-cycle hold restarts.
- `rst_ni` pulsed low mid-RUN for half a cycle → all outputs 0 before the next edge, and the heartbeat counter restarts at 0.

Source files
------------

// File: rtl/fpga_ctrl_pkg.sv
// fpga_ctrl_pkg: shared state encoding, default parameters and counter sizing for the FPGA reset/strap conditioner
package fpga_ctrl_pkg;
  typedef enum logic [1:0] {WAIT_LOCK, HOLD, RUN} rst_ctrl_state_e;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 65536;
  localparam int unsigned DEF_HOLD_CYCLES = 1024;
  localparam int unsigned DEF_CLK_LED_COUNT_LENGTH = 27;
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/strap_debouncer.sv
// strap_debouncer: synchronizes one raw switch and accepts a new level only after it has held for DEBOUNCE_CYCLES
module strap_debouncer
  import fpga_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic stable_o
);
  localparam int unsigned CW = cnt_w(DEBOUNCE_CYCLES);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0] cnt_q;
  logic synced;
  assign synced = sync_q[SYNC_STAGES-1];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_o <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
      if (synced == stable_o) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable_o <= synced;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
endmodule

// File: rtl/fpga_reset_strap_ctrl.sv
// fpga_reset_strap_ctrl: holds the SoC in reset until PLL lock has settled, latches debounced boot straps at release
module fpga_reset_strap_ctrl
  import fpga_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES          = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES          = DEF_HOLD_CYCLES,
  parameter int unsigned CLK_LED_COUNT_LENGTH = DEF_CLK_LED_COUNT_LENGTH
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pll_locked_i,
  input  logic boot_select_raw_i,
  input  logic execute_from_flash_raw_i,
  output logic soc_rst_no,
  output logic boot_select_o,
  output logic execute_from_flash_o,
  output logic rst_led_o,
  output logic clk_led_o
);
  localparam int unsigned HW = cnt_w(HOLD_CYCLES);
  rst_ctrl_state_e state_q, state_d;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic [HW-1:0] hold_q, hold_d;
  logic [CLK_LED_COUNT_LENGTH-1:0] hb_q;
  logic lock_s, load, bs_stable, ef_stable;
  assign lock_s = lock_sync_q[SYNC_STAGES-1];
  strap_debouncer #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bs_deb (
    .clk_i(clk_i), .rst_ni(rst_ni), .raw_i(boot_select_raw_i), .stable_o(bs_stable)
  );
  strap_debouncer #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ef_deb (
    .clk_i(clk_i), .rst_ni(rst_ni), .raw_i(execute_from_flash_raw_i), .stable_o(ef_stable)
  );
  always_comb begin
    state_d = state_q;
    hold_d  = '0;
    load    = 1'b0;
    unique case (state_q)
      WAIT_LOCK: state_d = lock_s ? HOLD : WAIT_LOCK;
      HOLD: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (hold_q == HW'(HOLD_CYCLES - 1)) begin
          state_d = RUN;
          load    = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      RUN:     state_d = lock_s ? RUN : WAIT_LOCK;
      default: state_d = WAIT_LOCK;
    endcase
  end
  // SoC reset comes straight from a flop so it cannot glitch during state transitions
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q              <= WAIT_LOCK;
      lock_sync_q          <= '0;
      hold_q               <= '0;
      hb_q                 <= '0;
      soc_rst_no           <= 1'b0;
      boot_select_o        <= 1'b0;
      execute_from_flash_o <= 1'b0;
    end else begin
      state_q              <= state_d;
      lock_sync_q          <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked_i};
      hold_q               <= hold_d;
      hb_q                 <= hb_q + 1'b1;
      soc_rst_no           <= (state_d == RUN);
      boot_select_o        <= load ? bs_stable : boot_select_o;
      execute_from_flash_o <= load ? ef_stable : execute_from_flash_o;
    end
  end
  assign rst_led_o = soc_rst_no;
  assign clk_led_o = hb_q[CLK_LED_COUNT_LENGTH-1];
endmodule

// File: tb/tb_fpga_reset_strap_ctrl.sv
// tb_fpga_reset_strap_ctrl: randomized scoreboard bench against a window-based reference model of the conditioner
module tb_fpga_reset_strap_ctrl;
  localparam int SS = 2;
  localparam int DB = 8;
  localparam int HC = 16;
  localparam int LW = 4;
  logic clk = 1'b0, rst_ni = 1'b1, pll = 1'b0, bs_raw = 1'b0, ef_raw = 1'b0;
  logic soc_rst_no, bs_o, ef_o, rst_led, clk_led;
  fpga_reset_strap_ctrl #(
    .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HC), .CLK_LED_COUNT_LENGTH(LW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .pll_locked_i(pll),
    .boot_select_raw_i(bs_raw), .execute_from_flash_raw_i(ef_raw),
    .soc_rst_no(soc_rst_no), .boot_select_o(bs_o), .execute_from_flash_o(ef_o),
    .rst_led_o(rst_led), .clk_led_o(clk_led)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic soc; logic bs; logic ef; logic hb;} exp_t;
  exp_t exp_q[$];
  int n_vec = 0, n_err = 0;
  int n_edge, run_len;
  bit m_bs, m_ef, st_bs, st_ef;
  bit lk_p[$], bs_p[$], ef_p[$], bs_w[$], ef_w[$];
  // A strap is accepted once the last DB synchronized samples all disagree with the accepted level
  function automatic bit all_is(input bit w[$], input bit v);
    if (w.size() != DB) return 1'b0;
    foreach (w[i]) if (w[i] != v) return 1'b0;
    return 1'b1;
  endfunction
  task automatic model_reset();
    n_edge = 0; run_len = 0;
    m_bs = 0; m_ef = 0; st_bs = 0; st_ef = 0;
    lk_p.delete(); bs_p.delete(); ef_p.delete(); bs_w.delete(); ef_w.delete();
    exp_q.delete();
    repeat (SS) begin lk_p.push_back(0); bs_p.push_back(0); ef_p.push_back(0); end
  endtask
  task automatic model_edge();
    bit sl, sb, se;
    sl = lk_p.pop_front(); sb = bs_p.pop_front(); se = ef_p.pop_front();
    lk_p.push_back(pll); bs_p.push_back(bs_raw); ef_p.push_back(ef_raw);
    bs_w.push_back(sb); if (bs_w.size() > DB) void'(bs_w.pop_front());
    ef_w.push_back(se); if (ef_w.size() > DB) void'(ef_w.pop_front());
    n_edge++;
    run_len = sl ? run_len + 1 : 0;
    if (run_len == HC + 1) begin m_bs = st_bs; m_ef = st_ef; end
    if (all_is(bs_w, !st_bs)) st_bs = !st_bs;
    if (all_is(ef_w, !st_ef)) st_ef = !st_ef;
    exp_q.push_back('{soc: run_len > HC, bs: m_bs, ef: m_ef, hb: n_edge[LW-1]});
  endtask
  task automatic step(input bit l, input bit b, input bit e);
    @(posedge clk);
    model_edge();
    #2;
    pll = l; bs_raw = b; ef_raw = e;
  endtask
  task automatic check_zero(input string tag);
    n_vec++;
    if ({soc_rst_no, rst_led, bs_o, ef_o, clk_led} != 5'b0) begin
      n_err++;
      $display("FAIL %s: got soc=%b led=%b bs=%b ef=%b hb=%b, expected all 0",
               tag, soc_rst_no, rst_led, bs_o, ef_o, clk_led);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if ({soc_rst_no, rst_led, bs_o, ef_o, clk_led} != {e.soc, e.soc, e.bs, e.ef, e.hb}) begin
        n_err++;
        $display("FAIL out@t=%0t: got soc=%b led=%b bs=%b ef=%b hb=%b, expected soc=%b led=%b bs=%b ef=%b hb=%b",
                 $time, soc_rst_no, rst_led, bs_o, ef_o, clk_led, e.soc, e.soc, e.bs, e.ef, e.hb);
      end
    end
  end
  initial begin
    int lk_left, bs_left, ef_left;
    model_reset();
    #1 rst_ni = 1'b0;
    pll = 1'b1; bs_raw = 1'b1; ef_raw = 1'b0;
    #11 check_zero("in_reset");
    @(negedge clk) rst_ni = 1'b1;
    repeat (30) step(1, 1, 0);
    repeat (12) step(1, 0, 0);
    repeat (6) step(1, 1, 1);
    repeat (4) step(0, 1, 1);
    repeat (40) step(1, 1, 1);
    repeat (5) step(1, 0, 1);
    repeat (12) step(1, 0, 0);
    repeat (3) step(0, 0, 0);
    repeat (12) step(1, 1, 0);
    repeat (2) step(0, 1, 0);
    repeat (40) step(1, 1, 0);
    lk_left = 0; bs_left = 0; ef_left = 0;
    for (int c = 0; c < 800; c++) begin
      bit l, b, e;
      l = pll; b = bs_raw; e = ef_raw;
      if (lk_left == 0) begin
        l = !pll;
        lk_left = l ? $urandom_range(5, 45) : $urandom_range(1, 4);
      end
      if (bs_left == 0) begin b = !bs_raw; bs_left = $urandom_range(1, 14); end
      if (ef_left == 0) begin e = !ef_raw; ef_left = $urandom_range(1, 14); end
      lk_left--; bs_left--; ef_left--;
      step(l, b, e);
    end
    repeat (30) step(1, bs_raw, ef_raw);
    @(negedge clk);
    #1 rst_ni = 1'b0;
    #1 check_zero("async_rst");
    model_reset();
    #2 rst_ni = 1'b1;
    repeat (30) step(1, 0, 1);
    repeat (2) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
